// File: rtl/disc_pkg.sv
// Shared constants, state encoding and saturating add for the GAN discriminator.
package disc_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_FRAC     = 16;
    localparam int DEF_N_PIXEL  = 9;
    localparam int DEF_N_HIDDEN = 3;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        L2   = 2'd1,
        L3   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic signed [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
    localparam logic signed [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

    function automatic logic signed [DEF_WIDTH-1:0] sat_add(
        input logic signed [DEF_WIDTH-1:0] a,
        input logic signed [DEF_WIDTH-1:0] b
    );
        logic signed [DEF_WIDTH:0] t;
        t = {a[DEF_WIDTH-1], a} + {b[DEF_WIDTH-1], b};
        if (t[DEF_WIDTH] != t[DEF_WIDTH-1])
            return t[DEF_WIDTH] ? SAT_MIN : SAT_MAX;
        return t[DEF_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/disc_mac_sat.sv
// Combinational multiply, arithmetic shift by FRAC and saturating accumulate.
module mac_sat
    import disc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic signed [WIDTH-1:0] acc,
    output logic signed [WIDTH-1:0] sum
);

    localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    // Overflow exists when the bits above the result sign are not a pure sign extension.
    function automatic logic signed [WIDTH-1:0] sat_prod(input logic signed [2*WIDTH-1:0] p);
        logic signed [2*WIDTH-1:0] s;
        logic        [WIDTH:0]     top;
        s   = p >>> FRAC;
        top = s[2*WIDTH-1:WIDTH-1];
        if ((&top) || !(|top))
            return s[WIDTH-1:0];
        return s[2*WIDTH-1] ? MINV : MAXV;
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_sum(
        input logic signed [WIDTH-1:0] x,
        input logic signed [WIDTH-1:0] y
    );
        logic signed [WIDTH:0] t;
        t = {x[WIDTH-1], x} + {y[WIDTH-1], y};
        if (t[WIDTH] != t[WIDTH-1])
            return t[WIDTH] ? MINV : MAXV;
        return t[WIDTH-1:0];
    endfunction

    logic signed [2*WIDTH-1:0] a_x;
    logic signed [2*WIDTH-1:0] b_x;
    logic signed [2*WIDTH-1:0] prod;

    assign a_x  = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_x  = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod = a_x * b_x;
    assign sum  = sat_sum(acc, sat_prod(prod));

endmodule

// File: rtl/discriminator.sv
// Time-multiplexed 9-3-1 discriminator: pixel load, hidden layer with ReLU, output logit.
module discriminator
    import disc_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int FRAC     = DEF_FRAC,
    parameter int N_PIXEL  = DEF_N_PIXEL,
    parameter int N_HIDDEN = DEF_N_HIDDEN
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                px_valid,
    output logic                                px_ready,
    input  logic signed [WIDTH-1:0]             px_data,
    input  logic [N_PIXEL*N_HIDDEN*WIDTH-1:0]   w_D2,
    input  logic [N_HIDDEN*WIDTH-1:0]           b_D2,
    input  logic [N_HIDDEN*WIDTH-1:0]           w_D3,
    input  logic signed [WIDTH-1:0]             b_D3,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [WIDTH-1:0]             score,
    output logic                                is_real
);

    localparam int KW = $clog2(N_PIXEL);
    localparam int JW = $clog2(N_HIDDEN);
    localparam logic [KW-1:0] K_LAST = KW'(N_PIXEL - 1);
    localparam logic [KW-1:0] H_LAST = KW'(N_HIDDEN - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N_HIDDEN - 1);

    function automatic logic signed [WIDTH-1:0] relu(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? '0 : x;
    endfunction

    logic signed [WIDTH-1:0] wd2 [N_HIDDEN][N_PIXEL];
    logic signed [WIDTH-1:0] bd2 [N_HIDDEN];
    logic signed [WIDTH-1:0] wd3 [N_HIDDEN];

    for (genvar gj = 0; gj < N_HIDDEN; gj++) begin : g_unpack_j
        for (genvar gk = 0; gk < N_PIXEL; gk++) begin : g_unpack_k
            assign wd2[gj][gk] = w_D2[(N_PIXEL*gj+gk)*WIDTH +: WIDTH];
        end
        assign bd2[gj] = b_D2[gj*WIDTH +: WIDTH];
        assign wd3[gj] = w_D3[gj*WIDTH +: WIDTH];
    end

    state_t                  state;
    logic [KW-1:0]           k;
    logic [JW-1:0]           j;
    logic signed [WIDTH-1:0] acc;
    logic signed [WIDTH-1:0] pix [N_PIXEL];
    logic signed [WIDTH-1:0] h   [N_HIDDEN];

    logic signed [WIDTH-1:0] mac_a;
    logic signed [WIDTH-1:0] mac_b;
    logic signed [WIDTH-1:0] mac_sum;

    // One MAC serves both layers; the operand source follows the FSM state.
    always_comb begin
        mac_a = pix[k];
        mac_b = wd2[j][k];
        if (state == L3) begin
            mac_a = h[k[JW-1:0]];
            mac_b = wd3[k[JW-1:0]];
        end
    end

    mac_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mac (
        .a   (mac_a),
        .b   (mac_b),
        .acc (acc),
        .sum (mac_sum)
    );

    assign px_ready  = (state == LOAD);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LOAD;
            k       <= '0;
            j       <= '0;
            acc     <= '0;
            score   <= '0;
            is_real <= 1'b0;
            for (int i = 0; i < N_PIXEL; i++)  pix[i] <= '0;
            for (int i = 0; i < N_HIDDEN; i++) h[i]   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (px_valid) begin
                        pix[k] <= px_data;
                        if (k == K_LAST) begin
                            k     <= '0;
                            j     <= '0;
                            acc   <= bd2[0];
                            state <= L2;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                // Hidden layer: the last MAC of a neuron goes straight through ReLU
                // while acc is reseeded for the next neuron (or the output layer).
                L2: begin
                    if (k == K_LAST) begin
                        h[j] <= relu(mac_sum);
                        k    <= '0;
                        if (j == J_LAST) begin
                            j     <= '0;
                            acc   <= b_D3;
                            state <= L3;
                        end else begin
                            j   <= j + 1'b1;
                            acc <= bd2[j + 1'b1];
                        end
                    end else begin
                        acc <= mac_sum;
                        k   <= k + 1'b1;
                    end
                end
                L3: begin
                    if (k == H_LAST) begin
                        score   <= mac_sum;
                        is_real <= !mac_sum[WIDTH-1] && (|mac_sum);
                        k       <= '0;
                        state   <= DONE;
                    end else begin
                        acc <= mac_sum;
                        k   <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_discriminator.sv
// Directed and randomized frames for the discriminator, scored against an arithmetic model.
module tb_discriminator;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            px_valid;
    logic            px_ready;
    logic [W-1:0]    px_data;
    logic [27*W-1:0] w_D2;
    logic [3*W-1:0]  b_D2;
    logic [3*W-1:0]  w_D3;
    logic [W-1:0]    b_D3;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    score;
    logic            is_real;

    int checks = 0;
    int errors = 0;

    int pixv [9];
    int w2   [27];
    int b2   [3];
    int w3   [3];
    int b3;

    discriminator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_data   (px_data),
        .w_D2      (w_D2),
        .b_D2      (b_D2),
        .w_D3      (w_D3),
        .b_D3      (b_D3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .score     (score),
        .is_real   (is_real)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint clamp(input longint x);
        if (x > 64'sd2147483647)  return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction

    // Fixed-point network evaluated with 64-bit integers and explicit clamping.
    function automatic int model_score();
        longint acc;
        longint hid [3];
        for (int jj = 0; jj < 3; jj++) begin
            acc = longint'(b2[jj]);
            for (int kk = 0; kk < 9; kk++)
                acc = clamp(acc + clamp((longint'(pixv[kk]) * longint'(w2[9*jj+kk])) >>> 16));
            hid[jj] = (acc < 0) ? 64'sd0 : acc;
        end
        acc = longint'(b3);
        for (int jj = 0; jj < 3; jj++)
            acc = clamp(acc + clamp((hid[jj] * longint'(w3[jj])) >>> 16));
        return int'(acc);
    endfunction

    task automatic apply_params();
        for (int i = 0; i < 27; i++) w_D2[i*W +: W] = w2[i];
        for (int i = 0; i < 3; i++) begin
            b_D2[i*W +: W] = b2[i];
            w_D3[i*W +: W] = w3[i];
        end
        b_D3 = b3;
    endtask

    task automatic fill(input int pv, input int wv2, input int bv2, input int wv3, input int bv3);
        for (int i = 0; i < 9; i++)  pixv[i] = pv;
        for (int i = 0; i < 27; i++) w2[i] = wv2;
        for (int i = 0; i < 3; i++) begin
            b2[i] = bv2;
            w3[i] = wv3;
        end
        b3 = bv3;
    endtask

    function automatic int rnd_small();
        return int'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
    endfunction

    task automatic randomize_frame(input bit wide);
        for (int i = 0; i < 9; i++)  pixv[i] = wide ? int'($urandom) : rnd_small();
        for (int i = 0; i < 27; i++) w2[i] = wide ? int'($urandom) : rnd_small();
        for (int i = 0; i < 3; i++) begin
            b2[i] = rnd_small();
            w3[i] = rnd_small();
        end
        b3 = rnd_small();
    endtask

    task automatic send_frame(input bit gaps);
        apply_params();
        for (int i = 0; i < 9; i++) begin
            if (gaps) begin
                px_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            px_valid = 1'b1;
            px_data  = pixv[i];
            @(negedge clk);
        end
        px_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input bit gaps, input logic [31:0] exp_score,
                             input logic exp_real, input int hold);
        int          lat;
        int          busy_ready;
        int          unstable;
        logic [31:0] held;
        send_frame(gaps);
        lat        = 0;
        busy_ready = 0;
        while (!out_valid && lat < 100) begin
            if (px_ready) busy_ready++;
            @(negedge clk);
            lat++;
        end
        check({tag, "/latency"}, lat, 30);
        check({tag, "/px_ready_busy"}, busy_ready, 0);
        check({tag, "/score"}, score, exp_score);
        check({tag, "/is_real"}, {31'd0, is_real}, {31'd0, exp_real});
        held     = score;
        unstable = 0;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (score !== held || out_valid !== 1'b1 || px_ready !== 1'b0) unstable++;
        end
        if (hold > 0) check({tag, "/hold_stable"}, unstable, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "/px_ready_after"}, {31'd0, px_ready}, 32'd1);
        check({tag, "/out_valid_after"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int e;
        int spurious;
        rst_n     = 1'b0;
        px_valid  = 1'b0;
        px_data   = '0;
        out_ready = 1'b0;
        fill(0, 0, 0, 0, 0);
        apply_params();
        repeat (2) @(negedge clk);
        check("rst/px_ready", {31'd0, px_ready}, 32'd1);
        check("rst/out_valid", {31'd0, out_valid}, 32'd0);
        check("rst/score", score, 32'd0);
        check("rst/is_real", {31'd0, is_real}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        fill(32'h0003_0000, 0, 0, 0, 32'h0001_0000);
        run_frame("bias_only", 1'b0, 32'h0001_0000, 1'b1, 0);

        fill(32'h0001_0000, 32'h0001_0000, 0, 0, 32'hFFFC_0000);
        w3[0] = 32'h0001_0000;
        run_frame("h9", 1'b0, 32'h0005_0000, 1'b1, 0);

        fill(32'h0001_0000, 32'hFFFF_0000, 0, 32'h0001_0000, 32'hFFFF_0000);
        run_frame("relu_clamp", 1'b0, 32'hFFFF_0000, 1'b0, 0);

        fill(32'h7FFF_0000, 32'h0001_0000, 0, 0, 0);
        w3[0] = 32'h0001_0000;
        w3[1] = 32'h0001_0000;
        run_frame("saturate", 1'b0, 32'h7FFF_FFFF, 1'b1, 0);

        randomize_frame(1'b0);
        e = model_score();
        run_frame("gaps_hold", 1'b1, e, e > 0, 10);

        for (int r = 0; r < 4; r++) begin
            randomize_frame(r[0]);
            e = model_score();
            run_frame($sformatf("rand%0d", r), r[1], e, e > 0, $urandom_range(0, 3));
        end

        // Abort a frame while the hidden layer is running.
        randomize_frame(1'b0);
        send_frame(1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst/px_ready", {31'd0, px_ready}, 32'd1);
        check("midrst/out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst/score", score, 32'd0);
        check("midrst/is_real", {31'd0, is_real}, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        spurious = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || px_ready !== 1'b1) spurious++;
        end
        check("midrst/no_output", spurious, 0);
        randomize_frame(1'b0);
        e = model_score();
        run_frame("after_rst", 1'b0, e, e > 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/discriminator.md
# discriminator

Sequential, time-multiplexed discriminator that scores the 3x3 images produced by the generator. It accepts the 9 pixels over a valid/ready stream, runs a 9-input, 3-neuron hidden layer and a 3-input, 1-neuron output layer through a single saturating MAC, and returns a signed fixed-point score with a real/fake flag. It sits downstream of `generator` in the GAN datapath, on the consuming end of the image interface.

## Interface
- `WIDTH`, 32: data width, signed Q(WIDTH-FRAC).FRAC
- `FRAC`, 16: fractional bits
- `N_PIXEL`, 9: pixels per image, row-major (1x1, 1x2, 1x3, 2x1 … 3x3)
- `N_HIDDEN`, 3: hidden-layer neurons

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `px_valid`  in  1  pixel present
- `px_ready`  out  1  block accepts a pixel
- `px_data`  in  WIDTH  signed pixel
- `w_D2`  in  N_PIXEL*N_HIDDEN*WIDTH  hidden weights; neuron j, input k at bits [(N_PIXEL*j+k+1)*WIDTH-1 : (N_PIXEL*j+k)*WIDTH]
- `b_D2`  in  N_HIDDEN*WIDTH  hidden biases; neuron j at [(j+1)*WIDTH-1 : j*WIDTH]
- `w_D3`  in  N_HIDDEN*WIDTH  output weights; input j at [(j+1)*WIDTH-1 : j*WIDTH]
- `b_D3`  in  WIDTH  output bias
- `out_valid`  out  1  score present
- `out_ready`  in  1  consumer takes score
- `score`  out  WIDTH  signed logit
- `is_real`  out  1  1 when score > 0

## Operation
- FSM states: LOAD, L2, L3, DONE. Reset state is LOAD.
- LOAD: `px_ready`=1. Each `px_valid & px_ready` edge writes `pix[k]` and increments k. Gaps in `px_valid` are allowed. When the 9th pixel is accepted, the FSM moves to L2, and j and k are cleared.
- L2: one MAC per cycle, `acc += sat(pix[k]*w_D2[j][k] >>> FRAC)`. The accumulator is seeded with `b_D2[j]` at neuron start. On k=8, `h[j] = max(0, acc_final)` (ReLU), acc is reseeded with the next bias, and j increments. This takes 27 cycles, after which the FSM moves to L3.
- L3: 3 MACs seeded with `b_D3`, with no activation. On the last MAC, `score` and `is_real` are registered and the FSM moves to DONE.
- DONE: `out_valid`=1, and `score` and `is_real` hold stable. On `out_valid & out_ready`, the FSM moves to LOAD.
- Arithmetic: the product is 2*WIDTH signed, shifted arithmetically right by FRAC, then saturated to WIDTH. Every add saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. There is no wrap-around anywhere.
- Weights and biases are read live and must be stable from the first pixel until `out_valid`. Changing them mid-frame gives an undefined score, but it must not corrupt the FSM.

## Timing
- Reset values: `px_ready`=1 (LOAD), `out_valid`=0, `score`=0, `is_real`=0. All internal counters, acc, `pix` and `h` are 0.
- Latency: if the 9th pixel is accepted at edge E0, `out_valid` rises after edge E30 (27 L2 edges plus 3 L3 edges).
- `px_ready`=0 in L2, L3 and DONE. There is no overlap of frames, and no same-cycle bypass from DONE to accepting a pixel. `px_ready` returns to 1 the cycle after the output handshake.
- `out_ready` may be held low indefinitely. `out_valid` and `score` must stay constant while it is low.
- Reset asserted mid-frame (any state) aborts the frame immediately. The partial frame is discarded and no `out_valid` is produced for it.
- Minimum frame period is 9 + 30 + 1 cycles with `out_ready` tied high.

## Structure
- Package `disc_pkg` holds:
  - FRAC and the default WIDTH, N_PIXEL and N_HIDDEN;
  - the state enum (LOAD, L2, L3, DONE);
  - the saturation limit constants;
  - a `sat_add` function.
- Sub-module `mac_sat`: a combinational signed multiply, shift and saturating add. It is instantiated once and shared by both layers.
- The top level holds the FSM, the counters k/j, the pixel buffer, the hidden registers and the output registers.

## Test plan
- All weights 0, `b_D2`=0, `b_D3`=0x00010000 -> `score`=0x00010000 and `is_real`=1, with `out_valid` exactly 30 cycles after the 9th pixel.
- Pixels all 0x00010000, `w_D2` all 0x00010000, `b_D2`=0, `w_D3`={1.0, 0, 0}, `b_D3`=0xFFFC0000 -> `h`=9.0 and `score`=0x00050000.
- `w_D2` all 0xFFFF0000 (ReLU clamps `h` to 0), `b_D3`=0xFFFF0000 -> `score`=0xFFFF0000 and `is_real`=0.
- Pixels 0x7FFF0000, `w_D2` all 1.0, `w_D3`={1.0, 1.0, 0}, biases 0 -> `h` saturates, giving `score`=0x7FFFFFFF.
- Pixels fed with random `px_valid` gaps and `out_ready` low for 10 cycles -> `score` is stable, `px_ready`=0 throughout, and `px_ready`=1 on the cycle after the handshake.
- `rst_n` pulsed low during L2 -> all outputs return to reset values, `px_ready`=1 after release, and the next full frame scores correctly.
